// File: rtl/mc_control_unit.sv
// Multi-cycle RISC-V control unit: IF/ID/EX/MEM/WB FSM with MEM_LAT-cycle memory phases.
// Optional feature: define CU_RETIRE_COUNT_EN to add the 32-bit `retired` pc_write counter.
module mc_control_unit #(
  parameter int MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] part_of_inst,
  input  logic       bcond,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       pc_to_reg,
  output logic       pc_write,
  output logic       is_ecall,
  output logic [1:0] pc_source,
  output logic [2:0] state
`ifdef CU_RETIRE_COUNT_EN
  ,
  output logic [31:0] retired
`endif
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  localparam logic [3:0] LAST_WAIT = 4'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       wait_last;

  logic is_arith, is_arith_imm, is_load, is_store;
  logic is_branch, is_jal, is_jalr, is_ecall_op, is_known;

  assign is_arith     = (part_of_inst == OP_ARITH);
  assign is_arith_imm = (part_of_inst == OP_ARITH_IMM);
  assign is_load      = (part_of_inst == OP_LOAD);
  assign is_store     = (part_of_inst == OP_STORE);
  assign is_branch    = (part_of_inst == OP_BRANCH);
  assign is_jal       = (part_of_inst == OP_JAL);
  assign is_jalr      = (part_of_inst == OP_JALR);
  assign is_ecall_op  = (part_of_inst == OP_ECALL);
  assign is_known     = is_arith | is_arith_imm | is_load | is_store |
                        is_branch | is_jal | is_jalr;

  assign wait_last = (wait_q == LAST_WAIT);
  assign state     = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IF;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    pc_to_reg  = 1'b0;
    pc_write   = 1'b0;
    is_ecall   = 1'b0;
    pc_source  = 2'd0;

    case (state_q)
      S_IF: begin
        mem_read = 1'b1;
        ir_write = wait_last;
        if (wait_last) state_d = S_ID;
      end

      S_ID: begin
        // ECALL and unknown opcodes retire here with a sequential PC update.
        if (is_ecall_op) begin
          is_ecall = 1'b1;
          pc_write = 1'b1;
          state_d  = S_IF;
        end else if (!is_known) begin
          pc_write = 1'b1;
          state_d  = S_IF;
        end else begin
          state_d = S_EX;
        end
      end

      S_EX: begin
        if (is_arith) begin
          alu_op = 2'b10;
        end else if (is_arith_imm) begin
          alu_src_b = 1'b1;
          alu_op    = 2'b10;
        end else if (is_load || is_store || is_jalr) begin
          alu_src_b = 1'b1;
        end else if (is_branch) begin
          alu_op = 2'b01;
        end

        if (is_branch) begin
          pc_write  = 1'b1;
          pc_source = bcond ? 2'd1 : 2'd0;
          state_d   = S_IF;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        i_or_d    = 1'b1;
        mem_read  = is_load;
        mem_write = is_store;
        if (wait_last) begin
          if (is_store) begin
            pc_write = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        pc_to_reg  = is_jal | is_jalr;
        pc_write   = 1'b1;
        pc_source  = is_jal ? 2'd1 : (is_jalr ? 2'd2 : 2'd0);
        state_d    = S_IF;
      end

      default: state_d = S_IF;
    endcase

    wait_d = (state_d != state_q) ? 4'd0 : wait_q + 4'd1;
  end

`ifdef CU_RETIRE_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_q <= 32'd0;
    else if (pc_write) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: random instruction stream checked cycle-by-cycle against
// an instruction-level sequence model, plus directed reset-abort and retire-wrap steps.
module tb_mc_control_unit;

  localparam int LAT = 3;

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_ECALL     = 7'b1110011;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] part_of_inst;
  logic       bcond;
  logic       mem_read, mem_write, i_or_d, ir_write, alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write, mem_to_reg, pc_to_reg, pc_write, is_ecall;
  logic [1:0] pc_source;
  logic [2:0] state;
`ifdef CU_RETIRE_COUNT_EN
  logic [31:0] retired;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_retired = 32'd0;
  logic [16:0] exp_q[$];
  logic [16:0] obs;

  mc_control_unit #(.MEM_LAT(LAT)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .part_of_inst (part_of_inst),
    .bcond        (bcond),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .i_or_d       (i_or_d),
    .ir_write     (ir_write),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .pc_to_reg    (pc_to_reg),
    .pc_write     (pc_write),
    .is_ecall     (is_ecall),
    .pc_source    (pc_source),
    .state        (state)
`ifdef CU_RETIRE_COUNT_EN
    ,
    .retired      (retired)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  assign obs = {state, mem_read, mem_write, i_or_d, ir_write, alu_src_b, alu_op,
                reg_write, mem_to_reg, pc_to_reg, pc_write, is_ecall, pc_source};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_checks++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Reference model: expected output vector per cycle for one instruction
  function automatic logic [16:0] vec(input logic [2:0] st, input logic mr, input logic mw,
                                      input logic iod, input logic irw, input logic asb,
                                      input logic [1:0] aop, input logic rw, input logic m2r,
                                      input logic p2r, input logic pcw, input logic ec,
                                      input logic [1:0] ps);
    return {st, mr, mw, iod, irw, asb, aop, rw, m2r, p2r, pcw, ec, ps};
  endfunction

  function automatic bit known(input logic [6:0] op);
    return op inside {OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR};
  endfunction

  task automatic build_expected(input logic [6:0] op, input logic b);
    logic ld, st, asb;
    logic [1:0] aop;
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    exp_q = {};
    for (int i = 0; i < LAT; i++)
      exp_q.push_back(vec(3'd0, 1, 0, 0, (i == LAT - 1), 0, 2'd0, 0, 0, 0, 0, 0, 2'd0));
    if (op == OP_ECALL) begin
      exp_q.push_back(vec(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 1, 2'd0));
      return;
    end
    if (!known(op)) begin
      exp_q.push_back(vec(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 1, 0, 2'd0));
      return;
    end
    exp_q.push_back(vec(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0, 2'd0));
    asb = (op == OP_ARITH_IMM) || ld || st || (op == OP_JALR);
    aop = (op == OP_ARITH || op == OP_ARITH_IMM) ? 2'b10 : (op == OP_BRANCH) ? 2'b01 : 2'b00;
    if (op == OP_BRANCH) begin
      exp_q.push_back(vec(3'd2, 0, 0, 0, 0, asb, aop, 0, 0, 0, 1, 0, b ? 2'd1 : 2'd0));
      return;
    end
    exp_q.push_back(vec(3'd2, 0, 0, 0, 0, asb, aop, 0, 0, 0, 0, 0, 2'd0));
    if (ld || st) begin
      for (int i = 0; i < LAT; i++)
        exp_q.push_back(vec(3'd3, ld, st, 1, 0, 0, 2'd0, 0, 0, 0, st && (i == LAT - 1), 0, 2'd0));
      if (st) return;
    end
    exp_q.push_back(vec(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, ld, (op == OP_JAL || op == OP_JALR), 1, 0,
                        (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0));
  endtask

  // Driver: runs one instruction starting at a negedge of IF cycle 1.
  // stop_at > 0 ends after checking that many cycles, leaving time mid-cycle.
  task automatic run_instr(input string name, input logic [6:0] op, input logic b,
                           input int stop_at);
    int n, pcw_seen;
    logic [16:0] e;
    build_expected(op, b);
    n = exp_q.size();
    pcw_seen = 0;
    for (int i = 0; i < n; i++) begin
      part_of_inst = op;
      bcond = b;
      #1;
      e = exp_q.pop_front();
      check($sformatf("%s op=%b cyc%0d", name, op, i + 1), 32'(obs), 32'(e));
      if (pc_write) pcw_seen++;
      if (e[3]) exp_retired = exp_retired + 32'd1;
      if (stop_at > 0 && i == stop_at - 1) return;
      @(negedge clk);
    end
    check($sformatf("%s op=%b pc_write_count", name, op), 32'(pcw_seen), 32'd1);
`ifdef CU_RETIRE_COUNT_EN
    check($sformatf("%s op=%b retired", name, op), retired, exp_retired);
`endif
  endtask

  logic [6:0] op_tab[8];
  logic [16:0] if1_vec;

  initial begin
    op_tab = '{OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL};
    if1_vec = vec(3'd0, 1, 0, 0, (LAT == 1), 0, 2'd0, 0, 0, 0, 0, 0, 2'd0);
    reset = 1'b1;
    part_of_inst = 7'd0;
    bcond = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check("reset_outputs", 32'(obs), 32'(if1_vec));
`ifdef CU_RETIRE_COUNT_EN
    check("reset_retired", retired, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Directed: one of each opcode, both branch outcomes, an unknown opcode
    run_instr("arith", OP_ARITH, 1'b0, 0);
    run_instr("load", OP_LOAD, 1'b0, 0);
    run_instr("branch_t", OP_BRANCH, 1'b1, 0);
    run_instr("branch_nt", OP_BRANCH, 1'b0, 0);
    run_instr("store", OP_STORE, 1'b1, 0);
    run_instr("jalr", OP_JALR, 1'b0, 0);
    run_instr("jal", OP_JAL, 1'b1, 0);
    run_instr("ecall", OP_ECALL, 1'b0, 0);
    run_instr("unknown", 7'b1111111, 1'b0, 0);

    // Reset in MEM cycle 1 of a STORE aborts it
    run_instr("store_abort", OP_STORE, 1'b0, LAT + 3);
    reset = 1'b1;
    #1;
    check("abort_state_now", 32'(state), 32'd0);
    check("abort_outputs", 32'(obs), 32'(if1_vec));
    exp_retired = 32'd0;
    @(negedge clk);
    check("abort_held_outputs", 32'(obs), 32'(if1_vec));
`ifdef CU_RETIRE_COUNT_EN
    check("abort_retired", retired, 32'd0);
`endif
    reset = 1'b0;
    run_instr("store_restart", OP_STORE, 1'b0, 0);

    // Random instruction stream
    for (int k = 0; k < 40; k++) begin
      logic [6:0] op;
      if ($urandom_range(0, 7) == 0) begin
        op = 7'($urandom_range(0, 127));
        while (known(op) || op == OP_ECALL) op = 7'($urandom_range(0, 127));
      end else begin
        op = op_tab[$urandom_range(0, 7)];
      end
      run_instr("rand", op, 1'($urandom_range(0, 1)), 0);
    end

`ifdef CU_RETIRE_COUNT_EN
    // Retire counter wraps from all-ones to zero
    force u_dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release u_dut.retired_q;
    exp_retired = 32'hFFFF_FFFF;
    run_instr("wrap", OP_ARITH_IMM, 1'b0, 0);
    check("wrap_zero", retired, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
